riscv_core_muldiv_unit: RTL
===========================

// Module: riscv_core_muldiv_unit
// PURPOSE
//  Iterative RV32M execute unit. Consumes the 4-bit alucontrol code that the ALU decoder
//  emits on its M-extension path (funct7[0]=1, opcode[5]=1) together with both operands.
//  Returns MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU results via a valid/ready handshake.
//  Sits beside the single-cycle ALU in EX; the pipeline stalls while o_muldiv_busy=1.
// PARAMETERS
//  XLEN  32  operand/result width; iteration counter width = $clog2(XLEN)+1
// PORTS
//  i_clk                   in   1     core clock, all state on rising edge
//  i_rst_n                 in   1     asynchronous, active-low reset
//  i_muldiv_valid          in   1     request valid
//  o_muldiv_ready          out  1     request accepted when valid&ready (==state IDLE)
//  i_muldiv_alucontrol     in   4     0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  i_muldiv_op_a           in   XLEN  rs1 (dividend / multiplicand)
//  i_muldiv_op_b           in   XLEN  rs2 (divisor / multiplier)
//  i_muldiv_flush          in   1     abort current op (branch mispredict/trap)
//  o_muldiv_valid          out  1     result valid, held until consumed
//  i_muldiv_result_ready   in   1     consumer takes result when valid&ready
//  o_muldiv_result         out  XLEN  result
//  o_muldiv_busy           out  1     1 in CALC/FIXUP/DONE
// BEHAVIOUR
//  Reset: state IDLE, o_muldiv_valid=0, o_muldiv_result=0, o_muldiv_busy=0, counter=0.
//  FSM IDLE->CALC->FIXUP->DONE->IDLE. Acceptance cycle = cycle 0.
//  IDLE: on valid, latch code, |op_a|,|op_b| per signedness, sign flags; counter=XLEN.
//  CALC: one radix-2 step/cycle, XLEN cycles (cycles 1..XLEN). MUL*: shift-add into
//   2*XLEN product. DIV*/REM*: restoring divide, quotient+remainder regs.
//  FIXUP (cycle XLEN+1): negate product if sign_a^sign_b (signed views only); quotient
//   negated if sign_a^sign_b, remainder takes sign of dividend; select low/high word.
//  DONE: o_muldiv_valid=1 from cycle XLEN+2; result stable until valid&result_ready,
//   then IDLE next edge. o_muldiv_ready=0 in DONE; no same-cycle back-to-back accept.
//  Signedness: MUL low word sign-agnostic; MULH s*s; MULHSU a signed, b unsigned; MULHU u*u.
//  Div by zero: quotient=all ones, remainder=op_a (no trap).
//  Signed overflow (op_a=-2^(XLEN-1), op_b=-1): DIV=op_a, REM=0.
//  Codes with bit3=1: accepted, DONE next cycle, result 0 (decoder never issues them).
//  Flush: any state -> IDLE next edge, o_muldiv_valid=0, result reg unchanged;
//   flush has priority over i_muldiv_valid in the same cycle (no accept).
//  Reset mid-operation: immediate return to reset values; no partial result emitted.
//  Inputs sampled only on acceptance; changes during CALC have no effect.
// CONFIGURATION
//  RISCV_MULDIV_BYPASS_EN defined: div-by-zero, signed overflow, and multiply with
//   either operand 0 skip CALC/FIXUP; DONE in cycle 1 with correct result.
//  Undefined: those cases run full XLEN+2 latency and yield identical result values
//   (divide path naturally produces the specified values).
// TESTING
//  MUL 7 * 0xFFFFFFFD -> 0xFFFFFFEB; o_muldiv_valid first high at cycle 34 (XLEN=32).
//  op_a=op_b=0xFFFFFFFF: MULHU->0xFFFFFFFE, MULH->0x00000000, MULHSU->0xFFFFFFFF.
//  DIV 0xFFFFFFF9/2->0xFFFFFFFD, REM->0xFFFFFFFF; DIVU 100/7->14, REMU->2.
//  DIV 5/0->0xFFFFFFFF, REM 5/0->5; DIV 0x80000000/0xFFFFFFFF->0x80000000, REM->0;
//   latency 1 with RISCV_MULDIV_BYPASS_EN, 34 without.
//  Flush at cycle 10 of DIVU -> IDLE at 11, valid never rises; new MUL 3*4 accepted -> 12.
//  Hold result_ready=0 for 5 cycles in DONE -> valid/result stable; i_rst_n low
//   mid-CALC -> valid=0, result=0, busy=0, ready=1 at once.

Source files
------------

// File: rtl/riscv_core_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Optional macro RISCV_MULDIV_BYPASS_EN: trivial cases (x/0, signed overflow, mul by 0) finish in one cycle.
module riscv_core_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_muldiv_valid,
    output logic            o_muldiv_ready,
    input  logic [3:0]      i_muldiv_alucontrol,
    input  logic [XLEN-1:0] i_muldiv_op_a,
    input  logic [XLEN-1:0] i_muldiv_op_b,
    input  logic            i_muldiv_flush,
    output logic            o_muldiv_valid,
    input  logic            i_muldiv_result_ready,
    output logic [XLEN-1:0] o_muldiv_result,
    output logic            o_muldiv_busy
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [3:0]        op_q;
    logic              sa_q, sb_q, div0_q;
    logic [2*XLEN-1:0] prod_q;
    logic [XLEN-1:0]   mcand_q;
    logic [XLEN-1:0]   result_q, result_d;

    function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] v);
        return '0 - v;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_dw(input logic [2*XLEN-1:0] v);
        return '0 - v;
    endfunction

    logic            accept, a_signed, b_signed, sa_in, sb_in;
    logic [XLEN-1:0] abs_a, abs_b;

    assign accept   = (state_q == IDLE) && i_muldiv_valid && !i_muldiv_flush;
    assign a_signed = (i_muldiv_alucontrol == 4'd1) || (i_muldiv_alucontrol == 4'd2) ||
                      (i_muldiv_alucontrol == 4'd4) || (i_muldiv_alucontrol == 4'd6);
    assign b_signed = (i_muldiv_alucontrol == 4'd1) || (i_muldiv_alucontrol == 4'd4) ||
                      (i_muldiv_alucontrol == 4'd6);
    assign sa_in    = a_signed && i_muldiv_op_a[XLEN-1];
    assign sb_in    = b_signed && i_muldiv_op_b[XLEN-1];
    assign abs_a    = sa_in ? neg_w(i_muldiv_op_a) : i_muldiv_op_a;
    assign abs_b    = sb_in ? neg_w(i_muldiv_op_b) : i_muldiv_op_b;

    logic byp;
`ifdef RISCV_MULDIV_BYPASS_EN
    logic [XLEN-1:0] byp_res;
    logic            b_zero, sovf;
    assign b_zero = (i_muldiv_op_b == '0);
    assign sovf   = b_signed && (i_muldiv_op_a == {1'b1, {(XLEN-1){1'b0}}}) && (i_muldiv_op_b == '1);
    assign byp    = !i_muldiv_alucontrol[3] &&
                    (i_muldiv_alucontrol[2] ? (b_zero || sovf) : (b_zero || (i_muldiv_op_a == '0)));
    always_comb begin
        byp_res = '0;
        if (i_muldiv_alucontrol[2]) begin
            if (b_zero)
                byp_res = i_muldiv_alucontrol[1] ? i_muldiv_op_a : '1;
            else
                byp_res = i_muldiv_alucontrol[1] ? '0 : i_muldiv_op_a;
        end
    end
`else
    assign byp = 1'b0;
`endif

    // One radix-2 step: multiply adds multiplicand into the high half then shifts right;
    // divide shifts {rem,quo} left and keeps the trial subtraction when it does not borrow.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next, div_next;
    logic [XLEN+1:0]   diff;

    assign mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    assign mul_next = {mul_sum, prod_q[XLEN-1:1]};
    assign diff     = {1'b0, prod_q[2*XLEN-1:XLEN-1]} - {2'b00, mcand_q};
    assign div_next = diff[XLEN+1] ? {prod_q[2*XLEN-2:0], 1'b0}
                                   : {diff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};

    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   fix_res;
    assign prod_s = (sa_q ^ sb_q) ? neg_dw(prod_q) : prod_q;

    always_comb begin
        fix_res = '0;
        case (op_q[2:0])
            3'd0:       fix_res = prod_s[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:       fix_res = prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5: fix_res = div0_q ? '1 :
                                  ((sa_q ^ sb_q) ? neg_w(prod_q[XLEN-1:0]) : prod_q[XLEN-1:0]);
            default:    fix_res = sa_q ? neg_w(prod_q[2*XLEN-1:XLEN]) : prod_q[2*XLEN-1:XLEN];
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (i_muldiv_alucontrol[3] || byp) ? DONE : CALC;
            CALC:    if (cnt_q == CW'(1)) state_d = FIXUP;
            FIXUP:   state_d = DONE;
            DONE:    if (i_muldiv_result_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (i_muldiv_flush) state_d = IDLE;
    end

    always_comb begin
        cnt_d    = cnt_q;
        result_d = result_q;
        if (accept) begin
            cnt_d = CW'(XLEN);
            if (i_muldiv_alucontrol[3]) result_d = '0;
`ifdef RISCV_MULDIV_BYPASS_EN
            else if (byp) result_d = byp_res;
`endif
        end else if (state_q == CALC) begin
            cnt_d = cnt_q - CW'(1);
        end else if (state_q == FIXUP && !i_muldiv_flush) begin
            result_d = fix_res;
        end
        if (i_muldiv_flush) cnt_d = '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    // Operand/datapath registers carry no reset: they are always reloaded on acceptance.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            op_q    <= i_muldiv_alucontrol;
            sa_q    <= sa_in;
            sb_q    <= sb_in;
            div0_q  <= (i_muldiv_op_b == '0);
            prod_q  <= {{XLEN{1'b0}}, i_muldiv_alucontrol[2] ? abs_a : abs_b};
            mcand_q <= i_muldiv_alucontrol[2] ? abs_b : abs_a;
        end else if (state_q == CALC) begin
            prod_q  <= op_q[2] ? div_next : mul_next;
        end
    end

    assign o_muldiv_ready  = (state_q == IDLE);
    assign o_muldiv_valid  = (state_q == DONE);
    assign o_muldiv_busy   = (state_q != IDLE);
    assign o_muldiv_result = result_q;
endmodule
